// File: rtl/led_driver.sv
// Multi-channel LED driver: per-channel off/on/blink/PWM with registered, polarity-selectable pins.
// Define LED_BREATHE_EN to make PWM mode follow a shared triangle-wave breathe ramp instead of duty_i.
module led_driver #(
  parameter int N_CH       = 3,
  parameter int CNT_W      = 16,
  parameter int PWM_W      = 8,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                  clk100,
  input  logic                  rst_n,
  input  logic [2*N_CH-1:0]     mode_i,
  input  logic [PWM_W*N_CH-1:0] duty_i,
  output logic                  tick_o,
  output logic                  blink_o,
  output logic [N_CH-1:0]       led_o
);

  localparam logic [1:0]       MODE_OFF   = 2'b00;
  localparam logic [1:0]       MODE_ON    = 2'b01;
  localparam logic [1:0]       MODE_BLINK = 2'b10;
  localparam logic [1:0]       MODE_PWM   = 2'b11;
  localparam logic [CNT_W-1:0] PRESC_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PWM_W-1:0] PWM_ONE    = {{(PWM_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_presc;
  logic             r_tick;
  logic             r_blink;
  logic [PWM_W-1:0] r_pwm_cnt;
  logic [PWM_W-1:0] r_duty_q [N_CH];
  logic [N_CH-1:0]  r_led;

  logic             w_presc_wrap;
  logic             w_pwm_wrap;
  logic [PWM_W-1:0] w_duty_src [N_CH];
  logic [N_CH-1:0]  w_pwm_on;
  logic [N_CH-1:0]  w_led_nxt;

  assign w_presc_wrap = &r_presc;
  assign w_pwm_wrap   = &r_pwm_cnt;

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      r_presc   <= '0;
      r_tick    <= 1'b0;
      r_blink   <= 1'b0;
      r_pwm_cnt <= '0;
    end else begin
      r_presc   <= r_presc + PRESC_ONE;
      r_tick    <= w_presc_wrap;
      r_pwm_cnt <= r_pwm_cnt + PWM_ONE;
      if (w_presc_wrap) r_blink <= ~r_blink;
    end
  end

`ifdef LED_BREATHE_EN
  logic [PWM_W-1:0] r_ramp;
  logic             r_ramp_dn;
  logic [PWM_W-1:0] w_ramp_nxt;

  assign w_ramp_nxt = r_ramp_dn ? (r_ramp - PWM_ONE) : (r_ramp + PWM_ONE);

  // Ramp reverses direction when it lands on either end, giving a triangle wave.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      r_ramp    <= '0;
      r_ramp_dn <= 1'b0;
    end else if (w_presc_wrap) begin
      r_ramp <= w_ramp_nxt;
      if (!r_ramp_dn && (&w_ramp_nxt))
        r_ramp_dn <= 1'b1;
      else if (r_ramp_dn && (w_ramp_nxt == '0))
        r_ramp_dn <= 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_duty_src[i] = duty_i[PWM_W*i +: PWM_W];
      if (mode_i[2*i +: 2] == MODE_PWM) w_duty_src[i] = r_ramp;
    end
  end
`else
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_duty_src[i] = duty_i[PWM_W*i +: PWM_W];
    end
  end
`endif

  // Shadow loads only at the period boundary so a duty change never cuts a period short.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) r_duty_q[i] <= '0;
    end else if (w_pwm_wrap) begin
      for (int i = 0; i < N_CH; i++) r_duty_q[i] <= w_duty_src[i];
    end
  end

  always_comb begin
    w_pwm_on  = '0;
    w_led_nxt = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_pwm_on[i] = (r_pwm_cnt < r_duty_q[i]);
      case (mode_i[2*i +: 2])
        MODE_OFF:   w_led_nxt[i] = 1'b0;
        MODE_ON:    w_led_nxt[i] = 1'b1;
        MODE_BLINK: w_led_nxt[i] = r_blink;
        default:    w_led_nxt[i] = w_pwm_on[i];
      endcase
    end
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) r_led <= {N_CH{ACTIVE_LOW}};
    else        r_led <= w_led_nxt ^ {N_CH{ACTIVE_LOW}};
  end

  assign tick_o  = r_tick;
  assign blink_o = r_blink;
  assign led_o   = r_led;

endmodule
